// File: rtl/circ_buf_ptr_ctrl_if.sv
// Handshake/status bundle for the circular-buffer pointer controller.
// The master side issues push/pop/flush/clr_err requests. The slave side
// (the controller) returns the pointers, occupancy and status flags.
interface circ_buf_ptr_ctrl_if #(
  parameter int COLUMNS   = 32,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 4
);
  localparam int AW = $clog2(COLUMNS);
  localparam int CW = $clog2(COLUMNS + 1);
  localparam int SW = $clog2(PAR_READ + 1);

  logic          push;
  logic          pop;
  logic [SW-1:0] stride;
  logic          flush;
  logic          clr_err;
  logic [AW-1:0] write_ptr;
  logic [AW-1:0] read_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          can_push;
  logic          can_pop;
  logic          err_ovf;
  logic          err_unf;

  modport master (
    output push, pop, stride, flush, clr_err,
    input  write_ptr, read_ptr, count, full, empty, can_push, can_pop,
           err_ovf, err_unf
  );

  modport slave (
    input  push, pop, stride, flush, clr_err,
    output write_ptr, read_ptr, count, full, empty, can_push, can_pop,
           err_ovf, err_unf
  );
endinterface

// File: rtl/circ_buf_ptr_ctrl.sv
// Pointer and occupancy controller for a circular buffer.
// Each accepted push commits PAR_WRITE entries. Each accepted pop retires a
// stride of up to PAR_READ entries, which slides the read window.
// The depth does not have to be a power of two, so pointer wrap is an
// explicit compare-and-subtract.
module circ_buf_ptr_ctrl #(
  parameter int COLUMNS   = 32,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 4
) (
  input logic            clk,
  input logic            rst,
  circ_buf_ptr_ctrl_if.slave bus
);
  localparam int AW = $clog2(COLUMNS);
  localparam int CW = $clog2(COLUMNS + 1);
  localparam int SW = $clog2(PAR_READ + 1);

  localparam logic [AW:0]   COLS_P = (AW+1)'(COLUMNS);
  localparam logic [AW:0]   PW_P   = (AW+1)'(PAR_WRITE);
  localparam logic [CW-1:0] COLS_C = CW'(COLUMNS);
  localparam logic [CW-1:0] PW_C   = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PR_C   = CW'(PAR_READ);
  localparam logic [SW-1:0] PR_S   = SW'(PAR_READ);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          can_push, can_pop;
  logic [SW-1:0] s_eff;
  logic          acc_push, acc_pop, rej_push, rej_pop;
  logic [CW:0]   cnt_sum;

  // The sum is at most 2*COLUMNS-1, so a single subtract of COLUMNS is enough.
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base,
                                         input logic [AW:0]   inc);
    logic [AW:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= COLS_P) sum = sum - COLS_P;
    return sum[AW-1:0];
  endfunction

  // Status flags depend on registered count only, so no input reaches an output.
  always_comb begin
    can_push = (COLS_C - cnt_q) >= PW_C;
    can_pop  = cnt_q >= PR_C;
  end

  // Accept and reject decisions use the pre-edge count; a zero stride is a silent no-op.
  always_comb begin
    s_eff    = (bus.stride > PR_S) ? PR_S : bus.stride;
    acc_push = bus.push & can_push;
    acc_pop  = bus.pop & can_pop & (bus.stride != '0);
    rej_push = bus.push & ~can_push;
    rej_pop  = bus.pop & ~can_pop & (bus.stride != '0);
  end

  // Next-state: flush wins and leaves the error flags alone. Otherwise push and pop apply together.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    cnt_sum = {1'b0, cnt_q};
    if (bus.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (acc_push) begin
        wp_d    = wrap(wp_q, PW_P);
        cnt_sum = cnt_sum + (CW+1)'(PAR_WRITE);
      end
      if (acc_pop) begin
        rp_d    = wrap(rp_q, (AW+1)'(s_eff));
        cnt_sum = cnt_sum - (CW+1)'(s_eff);
      end
      cnt_d = cnt_sum[CW-1:0];
      ovf_d = rej_push | (ovf_q & ~bus.clr_err);
      unf_d = rej_pop  | (unf_q & ~bus.clr_err);
    end
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.write_ptr = wp_q;
    bus.read_ptr  = rp_q;
    bus.count     = cnt_q;
    bus.full      = (cnt_q == COLS_C);
    bus.empty     = (cnt_q == '0);
    bus.can_push  = can_push;
    bus.can_pop   = can_pop;
    bus.err_ovf   = ovf_q;
    bus.err_unf   = unf_q;
  end
endmodule

// File: tb/tb_circ_buf_ptr_ctrl.sv
// Directed scoreboard bench for circ_buf_ptr_ctrl with COLUMNS=10,
// PAR_WRITE=3 and PAR_READ=4.
module tb_circ_buf_ptr_ctrl;
  localparam int COLUMNS = 10, PAR_WRITE = 3, PAR_READ = 4;

  typedef struct packed {
    logic [3:0] wp, rp, cnt;
    logic full, empty, cpush, cpop, ovf, unf;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  o;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t exp_q[$];

  circ_buf_ptr_ctrl_if #(.COLUMNS(COLUMNS), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) bus ();

  circ_buf_ptr_ctrl #(.COLUMNS(COLUMNS), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Expected flags follow directly from the hand-computed occupancy (depth 10).
  function automatic obs_t mk(int wp, int rp, int cnt, bit ovf, bit unf);
    obs_t o;
    o.wp    = 4'(wp);
    o.rp    = 4'(rp);
    o.cnt   = 4'(cnt);
    o.full  = (cnt == 10);
    o.empty = (cnt == 0);
    o.cpush = (cnt <= 7);
    o.cpop  = (cnt >= 4);
    o.ovf   = ovf;
    o.unf   = unf;
    return o;
  endfunction

  // Monitor: at every falling edge, compare the DUT state with all expectations due this cycle.
  initial begin
    obs_t a;
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      a = {bus.write_ptr, bus.read_ptr, bus.count, bus.full, bus.empty,
           bus.can_push, bus.can_pop, bus.err_ovf, bus.err_unf};
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        if (e.cyc != cyc || a !== e.o) begin
          n_bad++;
          $display("FAIL %s: got wp=%0d rp=%0d cnt=%0d full=%b empty=%b cpush=%b cpop=%b ovf=%b unf=%b, want wp=%0d rp=%0d cnt=%0d full=%b empty=%b cpush=%b cpop=%b ovf=%b unf=%b (due cyc %0d, at %0d)",
                   e.name, a.wp, a.rp, a.cnt, a.full, a.empty, a.cpush, a.cpop, a.ovf, a.unf,
                   e.o.wp, e.o.rp, e.o.cnt, e.o.full, e.o.empty, e.o.cpush, e.o.cpop, e.o.ovf, e.o.unf,
                   e.cyc, cyc);
        end
      end
    end
  end

  // Drive one request set for one clock and queue the state expected after that edge.
  task automatic step(input string name, input bit pu, input bit po, input int st,
                      input bit fl, input bit ce,
                      input int wp, input int rp, input int cnt, input bit ovf, input bit unf);
    exp_t e;
    @(negedge clk);
    bus.push    = pu;
    bus.pop     = po;
    bus.stride  = 3'(st);
    bus.flush   = fl;
    bus.clr_err = ce;
    e.cyc  = cyc + 1;
    e.o    = mk(wp, rp, cnt, ovf, unf);
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.stride  = 3'd0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  // Queue an expectation for the current cycle, with no clock edge in between.
  task automatic expect_now(input string name, input obs_t o);
    exp_t e;
    e.cyc  = cyc;
    e.o    = o;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    rst         = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.stride  = 3'd0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;

    @(posedge clk);
    #1;
    expect_now("in_reset", mk(0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    //   name            pu po st fl ce   wp rp cnt ovf unf
    step("idle",          0, 0, 0, 0, 0,   0, 0, 0,  0, 0);
    step("push1",         1, 0, 0, 0, 0,   3, 0, 3,  0, 0);
    step("push2",         1, 0, 0, 0, 0,   6, 0, 6,  0, 0);
    step("push3",         1, 0, 0, 0, 0,   9, 0, 9,  0, 0);
    step("push_ovf",      1, 0, 0, 0, 0,   9, 0, 9,  1, 0);
    step("pop4",          0, 1, 4, 0, 0,   9, 4, 5,  1, 0);
    step("push_wrap",     1, 0, 0, 0, 0,   2, 4, 8,  1, 0);
    step("clr_ovf",       0, 0, 0, 0, 1,   2, 4, 8,  0, 0);
    step("pop_stride0",   0, 1, 0, 0, 0,   2, 4, 8,  0, 0);
    step("pop4_to4",      0, 1, 4, 0, 0,   2, 8, 4,  0, 0);
    step("push_pop2",     1, 1, 2, 0, 0,   5, 0, 5,  0, 0);
    step("push_pop7",     1, 1, 7, 0, 0,   8, 4, 4,  0, 0);
    step("pop1",          0, 1, 1, 0, 0,   8, 5, 3,  0, 0);
    step("pop_unf",       0, 1, 1, 0, 0,   8, 5, 3,  0, 1);
    step("clr_and_unf",   0, 1, 1, 0, 1,   8, 5, 3,  0, 1);
    step("push_to6",      1, 0, 0, 0, 0,   1, 5, 6,  0, 1);
    step("flush_push",    1, 1, 4, 1, 0,   0, 0, 0,  0, 1);
    step("clr_unf",       0, 0, 0, 0, 1,   0, 0, 0,  0, 0);
    step("fill_a",        1, 0, 0, 0, 0,   3, 0, 3,  0, 0);
    step("fill_b",        1, 0, 0, 0, 0,   6, 0, 6,  0, 0);
    step("fill_c",        1, 0, 0, 0, 0,   9, 0, 9,  0, 0);
    step("pop2",          0, 1, 2, 0, 0,   9, 2, 7,  0, 0);
    step("push_full",     1, 0, 0, 0, 0,   2, 2, 10, 0, 0);
    step("push_at_full",  1, 0, 0, 0, 0,   2, 2, 10, 1, 0);
    step("pop3",          0, 1, 3, 0, 0,   2, 5, 7,  1, 0);

    // Asynchronous reset asserted between clock edges while count=7.
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_now("async_rst", mk(0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step("post_rst_push", 1, 0, 0, 0, 0,   3, 0, 3,  0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/circ_buf_ptr_ctrl.md
CIRC_BUF_PTR_CTRL -- requirements
Module: circ_buf_ptr_ctrl

Interface
REQ-001 Parameter COLUMNS, default 32: circular buffer depth in entries; SHALL be >= 2 and need not be a power of two.
REQ-002 Parameter PAR_WRITE, default 4: entries committed per accepted push; SHALL satisfy 1 <= PAR_WRITE <= COLUMNS.
REQ-003 Parameter PAR_READ, default 4: read window width; SHALL satisfy 1 <= PAR_READ <= COLUMNS.
REQ-004 Derived widths: AW = $clog2(COLUMNS); CW = $clog2(COLUMNS+1); SW = $clog2(PAR_READ+1).
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 push  input  1  request to commit PAR_WRITE entries at write_ptr.
REQ-008 pop  input  1  request to retire the oldest `stride` entries.
REQ-009 stride  input  SW  read-pointer advance per accepted pop (sliding-window stride).
REQ-010 flush  input  1  synchronous clear of pointers and occupancy.
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 write_ptr  output  AW  next write slot, registered.
REQ-013 read_ptr  output  AW  oldest valid slot and window base, registered.
REQ-014 count  output  CW  occupancy, registered, range 0..COLUMNS.
REQ-015 full, empty  output  1 each  count==COLUMNS; count==0.
REQ-016 can_push  output  1  (COLUMNS - count) >= PAR_WRITE.
REQ-017 can_pop  output  1  count >= PAR_READ, so a full window is valid.
REQ-018 err_ovf, err_unf  output  1 each  sticky rejected-push flag; sticky rejected-pop flag.

Function
REQ-019 full, empty, can_push and can_pop SHALL be combinational functions of the registered count only, with no input-to-output path.
REQ-020 Push accept: acc_push = push & can_push, evaluated on the pre-edge count.
REQ-021 Effective stride: s_eff = min(stride, PAR_READ).
REQ-022 Pop accept: acc_pop = pop & can_pop & (stride != 0); a pop with stride 0 SHALL be a no-op and SHALL NOT flag an error.
REQ-023 On acc_push: write_ptr <= wrap(write_ptr + PAR_WRITE).
REQ-024 On acc_pop: read_ptr <= wrap(read_ptr + s_eff).
REQ-025 wrap(x): compute the sum in AW+1 bits; if the sum >= COLUMNS, subtract COLUMNS; the result SHALL always be < COLUMNS.
REQ-026 Occupancy update: count <= count + (acc_push ? PAR_WRITE : 0) - (acc_pop ? s_eff : 0), computed without intermediate overflow; latency is one cycle.
REQ-027 When push and pop are accepted in the same cycle, both SHALL be applied and each SHALL be checked against the pre-edge count.
REQ-028 A push with can_push=0 SHALL leave write_ptr and count unchanged and SHALL set err_ovf.
REQ-029 A pop with stride != 0 and can_pop=0 SHALL leave read_ptr and count unchanged and SHALL set err_unf.
REQ-030 Error flags SHALL hold until clr_err; if clr_err and a new error occur in the same cycle, the flag SHALL be set.
REQ-031 flush SHALL have priority over push and pop: write_ptr, read_ptr and count SHALL go to 0, all requests in that cycle SHALL be ignored, and error flags SHALL be unchanged.
REQ-032 Invariant: count == (write_ptr - read_ptr) mod COLUMNS, except when full, where write_ptr == read_ptr.

Reset
REQ-033 While rst=0: write_ptr=0, read_ptr=0, count=0, err_ovf=0, err_unf=0; therefore empty=1, full=0, can_push=1, can_pop=0.
REQ-034 Reset SHALL take effect immediately, without a clock edge, including in the middle of any operation.
REQ-035 Release of reset SHALL be synchronised externally; the first state change is allowed only on the first rising edge after rst rises.

Verification (COLUMNS=10, PAR_WRITE=3, PAR_READ=4)
REQ-036 Assert rst low between clock edges with count=7 -> all outputs reach their reset values before the next edge.
REQ-037 Three pushes from reset -> count=9, write_ptr=9, can_push=0; a fourth push -> err_ovf=1, count=9, write_ptr=9.
REQ-038 From count=9, wp=9, rp=0: pop with stride=4 -> rp=4, count=5; then push -> wp=2 (wrap), count=8.
REQ-039 count=4, push plus pop with stride=2 in the same cycle -> count=5, both pointers advanced; stride=7 -> treated as 4.
REQ-040 count=3, pop with stride=1 -> rejected, err_unf=1, count=3; clr_err -> err_unf=0 on the next cycle.
REQ-041 count=6, flush plus push in the same cycle -> wp=0, rp=0, count=0, empty=1, error flags unchanged.
